lutram_mp: RTL and testbench

//  Multi-read-port distributed (LUT) RAM with a built-in clear sequencer; next generation of the

---
 rtl/lutram_mp.sv | 104 ++++++++++
 tb/tb_lutram_mp.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lutram_mp.sv
// lutram_mp: multi-read-port distributed RAM with a built-in clear sequencer.
// One write port and NumRd independent read ports. After reset, or when
// init_req is seen in IDLE, every word is swept to InitVal, one word per cycle.
// Optional feature macro: LUTRAM_MP_REG_OUT_EN
//   defined   -> registered read data per port (latency 1, write-first bypass)
//   undefined -> combinational read data (latency 0, read-old)
module lutram_mp #(
  parameter int              Depth   = 64,
  parameter int              Width   = 1,
  parameter int              NumRd   = 2,
  parameter logic [Width-1:0] InitVal = '0,
  localparam int             AW      = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_req,
  output logic                   init_busy,
  output logic                   init_done,
  output logic                   wready,
  input  logic                   wen,
  input  logic [AW-1:0]          waddr,
  input  logic [Width-1:0]       din,
  input  logic [NumRd*AW-1:0]    raddr,
  output logic [NumRd*Width-1:0] dout
);

  typedef enum logic {CLEAR, IDLE} state_t;

  // Depth as an AW+1 bit value so range checks work for non-power-of-two depths
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(Depth);
  localparam logic [AW-1:0] LAST    = AW'(Depth - 1);

  state_t        state;
  logic [AW-1:0] cnt;
  logic          wr_hit;

  (* ram_style = "distributed" *) logic [Width-1:0] mem [Depth];

  // Clear sequencer: sweep cnt 0..Depth-1, then idle until init_req
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      cnt       <= '0;
      init_busy <= 1'b1;
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b0;
      case (state)
        CLEAR: begin
          if (cnt == LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            init_busy <= 1'b0;
            init_done <= 1'b1;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        default: begin
          if (init_req) begin
            state     <= CLEAR;
            cnt       <= '0;
            init_busy <= 1'b1;
          end
        end
      endcase
    end
  end

  assign wready = !init_busy;
  assign wr_hit = wen && wready && ({1'b0, waddr} < DEPTH_W);

  // Storage: the sweep owns the write port while busy; user writes otherwise
  always_ff @(posedge clk) begin
    if (init_busy)   mem[cnt]   <= InitVal;
    else if (wr_hit) mem[waddr] <= din;
  end

  for (genvar i = 0; i < NumRd; i++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [Width-1:0] rd;

    assign ra = raddr[i*AW +: AW];
    // Partially swept contents are never exposed; out-of-range reads give InitVal
    assign rd = (init_busy || !({1'b0, ra} < DEPTH_W)) ? InitVal : mem[ra];

`ifdef LUTRAM_MP_REG_OUT_EN
    logic [Width-1:0] dq;

    // Output register with write-first bypass; held at InitVal through the sweep
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                        dq <= InitVal;
      else if (init_busy)             dq <= InitVal;
      else if (wr_hit && waddr == ra) dq <= din;
      else                            dq <= rd;
    end

    assign dout[i*Width +: Width] = dq;
`else
    assign dout[i*Width +: Width] = rd;
`endif
  end

endmodule

// File: tb/tb_lutram_mp.sv
// Scoreboard bench for lutram_mp: a 64-word and a 48-word instance, 8-bit
// words, two read ports each. Works with LUTRAM_MP_REG_OUT_EN defined or not.
module tb_lutram_mp;

  localparam logic [7:0] INIT = 8'hE5;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, req_a, req_b;
  logic       busy_a, busy_b, done_a, done_b, wrdy_a, wrdy_b;
  logic       wen_a, wen_b;
  logic [5:0] waddr_a, waddr_b;
  logic [7:0] din_a, din_b;
  logic [11:0] raddr_a, raddr_b;
  logic [15:0] dout_a, dout_b;

  always #5 clk = ~clk;

  lutram_mp #(.Depth(64), .Width(8), .NumRd(2), .InitVal(INIT)) u_a (
    .clk(clk), .rst(rst_a), .init_req(req_a), .init_busy(busy_a), .init_done(done_a),
    .wready(wrdy_a), .wen(wen_a), .waddr(waddr_a), .din(din_a), .raddr(raddr_a), .dout(dout_a));

  lutram_mp #(.Depth(48), .Width(8), .NumRd(2), .InitVal(INIT)) u_b (
    .clk(clk), .rst(rst_b), .init_req(req_b), .init_busy(busy_b), .init_done(done_b),
    .wready(wrdy_b), .wen(wen_b), .waddr(waddr_b), .din(din_b), .raddr(raddr_b), .dout(dout_b));

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { string tag; logic [7:0] val; } sb_t;
  sb_t sbq[$];

  logic [7:0] mdl [2][64];
  bit         bsy_m [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int dep(input bit sel);
    return sel ? 48 : 64;
  endfunction

  function automatic logic [7:0] exp_rd(input bit sel, input int a);
    if (bsy_m[sel] || a >= dep(sel)) return INIT;
    return mdl[sel][a];
  endfunction

  function automatic logic [7:0] get_dout(input bit sel, input int p);
    logic [15:0] d;
    d = sel ? dout_b : dout_a;
    return p ? d[15:8] : d[7:0];
  endfunction

  task automatic drive(input bit sel, input logic we, input int wa, input logic [7:0] d,
                       input int a0, input int a1);
    if (!sel) begin
      wen_a = we; waddr_a = 6'(wa); din_a = d; raddr_a = {6'(a1), 6'(a0)};
    end else begin
      wen_b = we; waddr_b = 6'(wa); din_b = d; raddr_b = {6'(a1), 6'(a0)};
    end
  endtask

  task automatic sb_push(input string tag, input logic [7:0] v);
    sb_t e;
    e.tag = tag; e.val = v;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input bit sel, input int p);
    sb_t e;
    if (sbq.size() == 0) begin
      chk("sb_underflow", 1, 0);
    end else begin
      e = sbq.pop_front();
      chk(e.tag, get_dout(sel, p), e.val);
    end
  endtask

  task automatic settle();
`ifdef LUTRAM_MP_REG_OUT_EN
    @(posedge clk); #1;
`else
    #1;
`endif
  endtask

  task automatic rd(input bit sel, input int a0, input int a1, input string tag);
    @(negedge clk);
    drive(sel, 1'b0, 0, 8'h00, a0, a1);
    sb_push({tag, "_p0"}, exp_rd(sel, a0));
    sb_push({tag, "_p1"}, exp_rd(sel, a1));
    settle();
    sb_pop(sel, 0);
    sb_pop(sel, 1);
  endtask

  task automatic wr(input bit sel, input int a, input logic [7:0] d);
    @(negedge clk);
    drive(sel, 1'b1, a, d, 0, 0);
    @(posedge clk);
    if (!bsy_m[sel] && a < dep(sel)) mdl[sel][a] = d;
    #1;
    drive(sel, 1'b0, 0, 8'h00, 0, 0);
  endtask

  task automatic start_sweep(input bit sel);
    bsy_m[sel] = 1'b1;
    for (int k = 0; k < 64; k++) mdl[sel][k] = INIT;
  endtask

  // Waits (bounded) for init_busy to fall; checks sweep length and the done pulse
  task automatic wait_sweep(input bit sel, input int t0, input string tag);
    int n = 0;
    while ((sel ? busy_b : busy_a) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_len"}, cyc - t0, dep(sel));
    chk({tag, "_done"}, sel ? done_b : done_a, 1);
    chk({tag, "_wrdy"}, sel ? wrdy_b : wrdy_a, 1);
    bsy_m[sel] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst_a = 1'b1; rst_b = 1'b1; req_a = 1'b0; req_b = 1'b0;
    drive(0, 1'b0, 0, 8'h00, 0, 5);
    drive(1, 1'b0, 0, 8'h00, 0, 0);
    start_sweep(0); start_sweep(1);
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_busy", busy_a, 1);
    chk("rst_done", done_a, 0);
    chk("rst_wrdy", wrdy_a, 0);
    chk("rst_dout0", dout_a[7:0], INIT);
    chk("rst_dout1", dout_a[15:8], INIT);

    // T1: sweep after reset release on both depths
    rst_a = 1'b0; rst_b = 1'b0;
    t0 = cyc;
    wait_sweep(1, t0, "t1_b");
    wait_sweep(0, t0, "t1_a");
    @(posedge clk); #1;
    chk("t1_done_pulse", done_a, 0);
    for (int k = 0; k < 64; k++) rd(0, k, 63 - k, "t1_init");

    // T5: 48-word instance, edge address and out-of-range accesses
    wr(1, 47, 8'h5A);
    wr(1, 50, 8'h33);
    rd(1, 47, 2, "t5_edge");
    for (int k = 50; k < 64; k++) rd(1, k, 47, "t5_oor");

    // T2: fill and concurrent reads
    for (int k = 0; k < 64; k++) wr(0, k, 8'(k + 1));
    for (int k = 0; k < 64; k++) rd(0, k, 63 - k, "t2_fill");
    for (int k = 0; k < 64; k += 9) rd(0, k, k, "t2_same");

    // T3: bulk clear on request, writes dropped and reads masked meanwhile
    @(negedge clk);
    req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0;
    t0 = cyc;
    start_sweep(0);
    chk("t3_wrdy_low", wrdy_a, 0);
    repeat (10) @(posedge clk);
    wr(0, 5, 8'hAA);
    rd(0, 10, 20, "t3_busy_rd");
    @(negedge clk);
    req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0;
    wait_sweep(0, t0, "t3");
    rd(0, 5, 6, "t3_cleared");

    // T6: same-cycle read and write to one address
    wr(0, 9, 8'h11);
    @(negedge clk);
    drive(0, 1'b1, 9, 8'h77, 9, 9);
`ifndef LUTRAM_MP_REG_OUT_EN
    sb_push("t6_old", 8'h11);
    #1;
    sb_pop(0, 0);
`endif
    sb_push("t6_new_p0", 8'h77);
    sb_push("t6_new_p1", 8'h77);
    @(posedge clk);
    mdl[0][9] = 8'h77;
    #1;
    sb_pop(0, 0);
    sb_pop(0, 1);
    drive(0, 1'b0, 0, 8'h00, 9, 9);
    rd(0, 9, 8, "t6_after");

    // T4: reset mid-sweep restarts, then a write on the init_done cycle
    wr(0, 4, 8'h44);
    @(negedge clk);
    req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0;
    start_sweep(0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    chk("t4_rst_busy", busy_a, 1);
    chk("t4_rst_dout", dout_a[7:0], INIT);
    @(negedge clk);
    rst_a = 1'b0;
    t0 = cyc;
    wait_sweep(0, t0, "t4");
    drive(0, 1'b1, 3, 8'h99, 3, 4);
    @(posedge clk);
    mdl[0][3] = 8'h99;
    #1;
    chk("t4_done_pulse", done_a, 0);
    drive(0, 1'b0, 0, 8'h00, 0, 0);
    rd(0, 3, 4, "t4_done_wr");

    chk("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
